// File: rtl/fpga_cmd_rx.sv
// SPI command receiver: ARM writes configuration frames that are staged as pending and
// applied to the output registers only at safe points (apply_ok), with optional readback.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | chip select high, waiting for a synchronised ncs fall
//   ST_SHIFT  | frame in progress, sampling mosi on synchronised spck rise
//   ST_DECODE | one cycle after ncs rise: check bit count, execute opcode
module fpga_cmd_rx #(
   parameter int NREG    = 4,
   parameter int DATA_W  = 8,
   parameter int FRAME_W = 16
) (
   input  logic                   ck_1356meg,
   input  logic                   rst,
   input  logic                   spck,
   input  logic                   ncs,
   input  logic                   mosi,
   output logic                   miso,
   input  logic                   apply_ok,
   output logic [NREG*DATA_W-1:0] regs,
   output logic [NREG-1:0]        upd,
   output logic                   err_frame
);

   localparam int CNT_W = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_DECODE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic ncs_s1, ncs_s2, ncs_s3;
   logic spck_s1, spck_s2, spck_s3;
   logic mosi_s1, mosi_s2;

   logic [CNT_W-1:0]   cnt;
   logic [FRAME_W-1:0] shreg;
   logic [FRAME_W-1:0] rb_q;
   logic [FRAME_W-1:0] rb_val;
   logic               rb_armed, rb_busy;
   logic [1:0]         settle;
   logic               rx_en;

   logic [DATA_W-1:0]  app_q    [NREG];
   logic [DATA_W-1:0]  pend_val [NREG];
   logic [NREG-1:0]    pend;

   logic               spck_rise, spck_fall, ncs_fall, ncs_rise;
   logic               cs_start, shift_en, dec_ok, dec_bad;
   logic               wr_en, clr_err, rb_load, clr_pend;
   logic [3:0]         opcode;
   logic [DATA_W-1:0]  payload;

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         ncs_s1  <= 1'b1;
         ncs_s2  <= 1'b1;
         ncs_s3  <= 1'b1;
         spck_s1 <= 1'b0;
         spck_s2 <= 1'b0;
         spck_s3 <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         ncs_s1  <= ncs;
         ncs_s2  <= ncs_s1;
         ncs_s3  <= ncs_s2;
         spck_s1 <= spck;
         spck_s2 <= spck_s1;
         spck_s3 <= spck_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   // rx_en blocks the fake ncs fall seen when reset lands in the middle of a frame
   assign spck_rise = spck_s2 & ~spck_s3;
   assign spck_fall = ~spck_s2 & spck_s3;
   assign ncs_fall  = ~ncs_s2 & ncs_s3 & rx_en;
   assign ncs_rise  = ncs_s2 & ~ncs_s3;

   always_ff @(posedge ck_1356meg) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (ncs_fall) state_d = ST_SHIFT;
         ST_SHIFT:  if (ncs_rise) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cs_start = 1'b0;
      shift_en = 1'b0;
      dec_ok   = 1'b0;
      dec_bad  = 1'b0;
      case (state_q)
         ST_IDLE:   cs_start = ncs_fall;
         ST_SHIFT:  shift_en = 1'b1;
         ST_DECODE: begin
            if (cnt == CNT_FULL) dec_ok  = 1'b1;
            else                 dec_bad = 1'b1;
         end
         default: ;
      endcase
   end

   assign opcode   = shreg[FRAME_W-1 -: 4];
   assign payload  = shreg[DATA_W-1:0];
   assign wr_en    = dec_ok && (opcode != 4'h0) && (opcode <= 4'(NREG));
   assign clr_err  = dec_ok && (opcode == 4'hD);
   assign rb_load  = dec_ok && (opcode == 4'hE);
   assign clr_pend = dec_ok && (opcode == 4'hF);

   always_comb begin
      rb_val = '0;
      for (int k = 0; k < NREG; k++) begin
         if (shreg[3:0] == 4'(k)) rb_val[DATA_W-1:0] = app_q[k];
      end
   end

   always_comb begin
      regs = '0;
      for (int k = 0; k < NREG; k++) regs[k*DATA_W +: DATA_W] = app_q[k];
   end

   assign miso = rb_busy & rb_q[FRAME_W-1];

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         cnt       <= '0;
         shreg     <= '0;
         rb_q      <= '0;
         rb_armed  <= 1'b0;
         rb_busy   <= 1'b0;
         err_frame <= 1'b0;
         pend      <= '0;
         upd       <= '0;
         settle    <= '0;
         rx_en     <= 1'b0;
         for (int k = 0; k < NREG; k++) begin
            app_q[k]    <= '0;
            pend_val[k] <= '0;
         end
      end else begin
         if (settle != 2'd2) settle <= settle + 2'd1;
         if ((settle == 2'd2) && ncs_s2) rx_en <= 1'b1;

         if (cs_start) begin
            cnt     <= '0;
            shreg   <= '0;
            rb_busy <= rb_armed;
         end else if (shift_en && spck_rise) begin
            shreg <= {shreg[FRAME_W-2:0], mosi_s2};
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
         end

         if (shift_en && spck_fall && rb_busy) rb_q <= {rb_q[FRAME_W-2:0], 1'b0};

         for (int k = 0; k < NREG; k++) begin
            upd[k] <= apply_ok && pend[k] && (pend_val[k] != app_q[k]);
            if (apply_ok && pend[k]) begin
               app_q[k] <= pend_val[k];
               pend[k]  <= 1'b0;
            end
         end

         if (dec_bad) err_frame <= 1'b1;
         if (clr_err) err_frame <= 1'b0;

         if ((dec_ok || dec_bad) && rb_busy) begin
            rb_busy  <= 1'b0;
            rb_armed <= 1'b0;
         end
         if (rb_load) begin
            rb_q     <= rb_val;
            rb_armed <= 1'b1;
         end

         // decode writes come after the apply loop so a same-cycle write stays pending
         for (int k = 0; k < NREG; k++) begin
            if (wr_en && (opcode == 4'(k + 1))) begin
               pend_val[k] <= payload;
               pend[k]     <= 1'b1;
            end
         end
         if (clr_pend) pend <= '0;
      end
   end

endmodule

// File: tb/tb_fpga_cmd_rx.sv
// Bench for fpga_cmd_rx: drives SPI frames slowly relative to ck_1356meg and scores
// register updates, framing errors and readback data against expected values.
module tb_fpga_cmd_rx;

   localparam int NREG   = 4;
   localparam int DATA_W = 8;

   logic                   clk = 1'b0;
   logic                   rst, spck, ncs, mosi, apply_ok;
   logic                   miso, err_frame;
   logic [NREG*DATA_W-1:0] regs;
   logic [NREG-1:0]        upd;

   always #5 clk = ~clk;

   fpga_cmd_rx #(.NREG(NREG), .DATA_W(DATA_W), .FRAME_W(16)) dut (
      .ck_1356meg (clk),
      .rst        (rst),
      .spck       (spck),
      .ncs        (ncs),
      .mosi       (mosi),
      .miso       (miso),
      .apply_ok   (apply_ok),
      .regs       (regs),
      .upd        (upd),
      .err_frame  (err_frame)
   );

   typedef struct packed {
      logic [3:0]  upd;
      logic [31:0] regs;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e_in, e_out;
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          rise_cyc;
   logic [31:0] exp_regs;
   logic [15:0] cap;
   logic [15:0] part_frame;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // every nonzero upd must match the oldest expected update, including its cycle
   always @(negedge clk) begin
      if (!rst && upd !== '0) begin
         if (sb.size() == 0) begin
            chk("upd_unexpected", 32'(upd), 32'h0);
         end else begin
            e_out = sb.pop_front();
            chk("upd", 32'(upd), 32'(e_out.upd));
            chk("regs_at_upd", regs, e_out.regs);
            chk("upd_cycle", 32'(cyc), e_out.cyc);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic [31:0] f, input int nbits, input logic [3:0] eu);
      cap = '0;
      ncs = 1'b0;
      wait_clk(4);
      for (int i = 0; i < nbits; i++) begin
         mosi = f[nbits-1-i];
         wait_clk(4);
         cap  = {cap[14:0], miso};
         spck = 1'b1;
         wait_clk(4);
         spck = 1'b0;
      end
      wait_clk(4);
      ncs = 1'b1;
      rise_cyc = cyc;
      if (eu != '0) begin
         e_in.upd  = eu;
         e_in.regs = exp_regs;
         e_in.cyc  = 32'(rise_cyc + 5);
         sb.push_back(e_in);
      end
   endtask

   task automatic expect_apply_now(input logic [3:0] eu);
      e_in.upd  = eu;
      e_in.regs = exp_regs;
      e_in.cyc  = 32'(cyc + 1);
      sb.push_back(e_in);
   endtask

   initial begin
      rst = 1'b1; ncs = 1'b1; spck = 1'b0; mosi = 1'b0; apply_ok = 1'b1;
      exp_regs = '0;
      wait_clk(3);
      chk("rst_regs", regs, 32'h0);
      chk("rst_upd", 32'(upd), 32'h0);
      chk("rst_err", 32'(err_frame), 32'h0);
      chk("rst_miso", 32'(miso), 32'h0);
      rst = 1'b0;
      wait_clk(6);

      // write slot0, then identical write must not pulse upd
      exp_regs = 32'h0000_00A5;
      xfer(32'h10A5, 16, 4'b0001);
      wait_clk(12);
      xfer(32'h10A5, 16, 4'b0000);
      wait_clk(12);
      chk("same_value_regs", regs, exp_regs);

      // held writes, last one wins
      apply_ok = 1'b0;
      xfer(32'h2011, 16, 4'b0000);
      wait_clk(12);
      xfer(32'h2022, 16, 4'b0000);
      wait_clk(12);
      chk("held_regs", regs, exp_regs);
      apply_ok = 1'b1;
      exp_regs = 32'h0000_22A5;
      expect_apply_now(4'b0010);
      wait_clk(4);

      // apply_ok only in the decode cycle: write must stay pending
      apply_ok = 1'b0;
      xfer(32'h2033, 16, 4'b0000);
      wait_clk(3);
      apply_ok = 1'b1;
      wait_clk(1);
      apply_ok = 1'b0;
      wait_clk(10);
      chk("decode_cycle_hold", regs, exp_regs);
      apply_ok = 1'b1;
      exp_regs = 32'h0000_33A5;
      expect_apply_now(4'b0010);
      wait_clk(4);

      // framing errors
      xfer(32'h0000_1066, 15, 4'b0000);
      wait_clk(12);
      chk("err_15bit", 32'(err_frame), 32'h1);
      chk("regs_15bit", regs, exp_regs);
      xfer(32'h0001_1077, 17, 4'b0000);
      wait_clk(12);
      chk("err_17bit", 32'(err_frame), 32'h1);
      chk("regs_17bit", regs, exp_regs);
      xfer(32'hD000, 16, 4'b0000);
      wait_clk(12);
      chk("err_cleared", 32'(err_frame), 32'h0);
      xfer(32'h0, 0, 4'b0000);
      wait_clk(12);
      chk("err_no_spck", 32'(err_frame), 32'h1);
      xfer(32'hD000, 16, 4'b0000);
      wait_clk(12);
      chk("err_cleared2", 32'(err_frame), 32'h0);

      // readback of slot2
      exp_regs = 32'h003C_33A5;
      xfer(32'h303C, 16, 4'b0100);
      wait_clk(12);
      xfer(32'hE002, 16, 4'b0000);
      chk("miso_unarmed", 32'(cap), 32'h0);
      wait_clk(12);
      xfer(32'h0000, 16, 4'b0000);
      chk("miso_readback", 32'(cap), 32'h003C);
      wait_clk(12);
      xfer(32'h0000, 16, 4'b0000);
      chk("miso_disarmed", 32'(cap), 32'h0);
      wait_clk(12);

      // clear-pending discards a held write
      apply_ok = 1'b0;
      xfer(32'h4077, 16, 4'b0000);
      wait_clk(12);
      xfer(32'hF000, 16, 4'b0000);
      wait_clk(12);
      apply_ok = 1'b1;
      wait_clk(6);
      chk("pend_cleared_regs", regs, exp_regs);

      // reset in the middle of a frame
      part_frame = 16'h1055;
      ncs = 1'b0;
      wait_clk(4);
      for (int i = 0; i < 8; i++) begin
         mosi = part_frame[15-i];
         wait_clk(4);
         spck = 1'b1;
         wait_clk(4);
         spck = 1'b0;
      end
      wait_clk(2);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      exp_regs = '0;
      wait_clk(4);
      ncs = 1'b1;
      wait_clk(12);
      chk("abort_err", 32'(err_frame), 32'h0);
      chk("abort_regs", regs, 32'h0);
      exp_regs = 32'h0000_0055;
      xfer(32'h1055, 16, 4'b0001);
      wait_clk(12);
      chk("post_abort_regs", regs, exp_regs);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpga_cmd_rx.md
FPGA_CMD_RX -- requirements
Module: fpga_cmd_rx

Interface
REQ-001 Parameter NREG, default 4: number of configuration registers; legal range 1..12.
REQ-002 Parameter DATA_W, default 8: register width; legal range 1..12.
REQ-003 Parameter FRAME_W, fixed 16: SPI frame length in bits; opcode = frame[15:12], payload = frame[DATA_W-1:0].
REQ-004 ck_1356meg  in  1  sole clock; all state SHALL be updated on its rising edge only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 spck  in  1  SPI clock from ARM, asynchronous to ck_1356meg.
REQ-007 ncs  in  1  SPI chip select, active low, asynchronous.
REQ-008 mosi  in  1  SPI data in, MSB first, asynchronous.
REQ-009 miso  out  1  readback data, MSB first.
REQ-010 apply_ok  in  1  safe-point qualifier; pending writes SHALL be applied only while high (glitch-free carrier switching).
REQ-011 regs  out  NREG*DATA_W  applied register values; register k occupies bits [k*DATA_W +: DATA_W].
REQ-012 upd  out  NREG  one-cycle pulse on bit k when register k changes its applied value.
REQ-013 err_frame  out  1  sticky framing-error flag.

Function
REQ-014 spck, ncs and mosi SHALL each pass through a 2-flop synchroniser before use; spck edges SHALL be detected from the synchronised value (a third flop).
REQ-015 spck SHALL be at most ck_1356meg/4; faster spck is out of specification.
REQ-016 Synchronised ncs falling edge SHALL clear the bit counter and shift register; the state SHALL move IDLE -> SHIFT.
REQ-017 In SHIFT, each synchronised spck rising edge SHALL shift mosi into shift register bit 0 and increment the bit counter; counter SHALL saturate at FRAME_W+1.
REQ-018 Synchronised ncs rising edge SHALL move SHIFT -> DECODE for exactly one cycle, then DECODE -> IDLE.
REQ-019 In DECODE with bit count != FRAME_W, the frame SHALL be discarded and err_frame set; no register or pending state changes.
REQ-020 In DECODE with count == FRAME_W: opcode 0x0 NOP; opcode 1..NREG writes payload into pending slot (opcode-1) and sets its pending bit; opcodes NREG+1..0xC ignored (no error); 0xD clears err_frame; 0xE loads readback register from regs slot payload[3:0] (index >= NREG loads zero); 0xF clears all pending bits.
REQ-021 A second write to a slot whose pending bit is set SHALL overwrite the pending value (last write wins).
REQ-022 Each cycle with apply_ok high, every slot with pending set SHALL copy pending to applied and clear pending; upd[k] SHALL pulse the following cycle only if the applied value differed.
REQ-023 A DECODE write and apply_ok high in the same cycle: the write SHALL stay pending (not applied) and SHALL apply at the next apply_ok-high cycle.
REQ-024 Readback: after a 0xE frame, during the next frame miso SHALL present readback[FRAME_W-1] after ncs falls and shift to the next bit on each synchronised spck falling edge; readback is the DATA_W value right-aligned in 16 bits, zero-extended.
REQ-025 miso SHALL be 0 when no readback is armed; readback SHALL disarm at the end of the frame that shifts it out.
REQ-026 Latency: ncs rising at pin to pending set SHALL be 4 ck_1356meg cycles (3 sync/edge + DECODE); pending to applied SHALL be 1 cycle with apply_ok high.
REQ-027 ncs rising without any spck edge SHALL be a framing error (count 0).

Reset
REQ-028 rst high SHALL, on the next clock edge, set state IDLE, regs, pending values, pending bits, readback, bit counter, upd, miso and err_frame to 0, and synchroniser flops to ncs=1, spck=0, mosi=0.
REQ-029 rst asserted mid-frame SHALL abort the frame; the subsequent ncs rising SHALL NOT decode or raise err_frame (state is IDLE).

Verification
REQ-030 rst, apply_ok=1, frame 0x10A5 -> regs[7:0]=0xA5 4 cycles after ncs rise +1, upd=0001 for one cycle; repeat same frame -> no upd pulse.
REQ-031 apply_ok=0, frames 0x2011 then 0x2022 -> regs slot1 unchanged; raise apply_ok -> slot1=0x22, upd=0010 once.
REQ-032 15-bit frame then 17-bit frame -> err_frame=1, regs unchanged; frame 0xD000 -> err_frame=0.
REQ-033 Slot2=0x3C applied, frame 0xE002 then frame 0x0000 -> miso bits 0x003C MSB first on successive spck; frame after that -> miso=0.
REQ-034 apply_ok=0, frame 0x4077 then 0xF000, then apply_ok=1 -> slot3 stays 0, no upd.
REQ-035 rst pulsed after 8 spck edges of frame 0x1055, ncs then rises -> err_frame=0, regs=0; next full frame 0x1055 applies normally.
